// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the ICACHE and DCACHE refill/write-back engines.
// Registered round-robin grant, owner-only routing of ready/rdata, sticky protocol-error flag.
module mem_port_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_mem_read,
  input  logic              ic_mem_write,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  input  logic [DATA_W-1:0] ic_mem_wdata,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              proto_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             last_d_r;
  logic [CNT_W-1:0] to_cnt_r;
  logic             ic_req_s;
  logic             dc_req_s;
  logic             granted_s;
  logic             own_req_s;
  logic             err_s;

  assign ic_req_s  = ic_mem_read | ic_mem_write;
  assign dc_req_s  = dc_mem_read | dc_mem_write;
  assign granted_s = (state_r == GRANT_I) || (state_r == GRANT_D);
  // The shared strobes already follow the owner, so they double as the owner's request.
  assign own_req_s = mem_read | mem_write;

  // Route the owner's request to memory and the memory response back to the owner only.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = {ADDR_W{1'b0}};
    mem_wdata    = {DATA_W{1'b0}};
    ic_mem_ready = 1'b0;
    ic_mem_rdata = {DATA_W{1'b0}};
    dc_mem_ready = 1'b0;
    dc_mem_rdata = {DATA_W{1'b0}};
    case (state_r)
      GRANT_I: begin
        mem_read     = ic_mem_read;
        mem_write    = ic_mem_write;
        mem_addr     = ic_mem_addr;
        mem_wdata    = ic_mem_wdata;
        ic_mem_ready = mem_ready;
        ic_mem_rdata = mem_rdata;
      end
      GRANT_D: begin
        mem_read     = dc_mem_read;
        mem_write    = dc_mem_write;
        mem_addr     = dc_mem_addr;
        mem_wdata    = dc_mem_wdata;
        dc_mem_ready = mem_ready;
        dc_mem_rdata = mem_rdata;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  // Grant selection in IDLE; release on completion or when the owner abandons its request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ic_req_s && dc_req_s) begin
          state_nxt_s = last_d_r ? GRANT_I : GRANT_D;
        end else if (ic_req_s) begin
          state_nxt_s = GRANT_I;
        end else if (dc_req_s) begin
          state_nxt_s = GRANT_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready || !own_req_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Protocol violations: read+write together, owner drop without completion, or wait limit hit.
  always_comb begin
    err_s = 1'b0;
    if (granted_s) begin
      err_s = (mem_read && mem_write) ||
              (!mem_ready && !own_req_s) ||
              (!mem_ready && (to_cnt_r >= (TO_LIMIT - CNT_W'(1))));
    end else begin
      err_s = 1'b0;
    end
  end

  // State, fairness pointer, wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      last_d_r  <= 1'b0;
      to_cnt_r  <= {CNT_W{1'b0}};
      proto_err <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && (state_nxt_s != IDLE)) begin
        last_d_r <= (state_nxt_s == GRANT_D);
      end
      // Counter rests at zero in IDLE so every grant starts counting from a clean value.
      if (!granted_s) begin
        to_cnt_r <= {CNT_W{1'b0}};
      end else if (!mem_ready && (to_cnt_r != TO_LIMIT)) begin
        to_cnt_r <= to_cnt_r + CNT_W'(1);
      end
      if (err_s) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TO = 12;

  logic          clk;
  logic          rst_n;
  logic          ic_mem_read, ic_mem_write, dc_mem_read, dc_mem_write;
  logic [AW-1:0] ic_mem_addr, dc_mem_addr, mem_addr;
  logic [DW-1:0] ic_mem_wdata, dc_mem_wdata, ic_mem_rdata, dc_mem_rdata;
  logic          ic_mem_ready, dc_mem_ready;
  logic          mem_read, mem_write, mem_ready, proto_err;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_mem_read(ic_mem_read), .ic_mem_write(ic_mem_write), .ic_mem_addr(ic_mem_addr),
    .ic_mem_wdata(ic_mem_wdata), .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write), .dc_mem_addr(dc_mem_addr),
    .dc_mem_wdata(dc_mem_wdata), .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // owner: 0 none, 1 ICACHE, 2 DCACHE; expected port values follow from the owner's inputs
  task automatic check_cycle(input string tag, input int owner, input logic e_ic_rdy,
                             input logic e_dc_rdy, input logic e_perr);
    logic e_rd, e_wr;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_wd, e_ird, e_drd;
    e_rd = 1'b0; e_wr = 1'b0; e_ad = '0; e_wd = '0; e_ird = '0; e_drd = '0;
    if (owner == 1) begin
      e_rd = ic_mem_read; e_wr = ic_mem_write; e_ad = ic_mem_addr; e_wd = ic_mem_wdata;
      e_ird = mem_rdata;
    end else if (owner == 2) begin
      e_rd = dc_mem_read; e_wr = dc_mem_write; e_ad = dc_mem_addr; e_wd = dc_mem_wdata;
      e_drd = mem_rdata;
    end
    chk({tag, ".mem_read"},  DW'(mem_read),     DW'(e_rd));
    chk({tag, ".mem_write"}, DW'(mem_write),    DW'(e_wr));
    chk({tag, ".mem_addr"},  DW'(mem_addr),     DW'(e_ad));
    chk({tag, ".mem_wdata"}, mem_wdata,         e_wd);
    chk({tag, ".ic_ready"},  DW'(ic_mem_ready), DW'(e_ic_rdy));
    chk({tag, ".dc_ready"},  DW'(dc_mem_ready), DW'(e_dc_rdy));
    chk({tag, ".ic_rdata"},  ic_mem_rdata,      e_ird);
    chk({tag, ".dc_rdata"},  dc_mem_rdata,      e_drd);
    chk({tag, ".proto_err"}, DW'(proto_err),    DW'(e_perr));
  endtask

  // One directed cycle: drive after the falling edge, check 1 ns later.
  task automatic cyc(input string tag, input logic r, input logic icr, input logic icw,
                     input logic dcr, input logic dcw, input logic mr, input int owner,
                     input logic eic, input logic edc, input logic ep);
    @(negedge clk);
    rst_n = r; ic_mem_read = icr; ic_mem_write = icw;
    dc_mem_read = dcr; dc_mem_write = dcw; mem_ready = mr; mem_rdata = rnd128();
    #1;
    check_cycle(tag, owner, eic, edc, ep);
  endtask

  typedef struct {
    logic r, icr, icw, dcr, dcw, mr;
    int   owner;
    logic eic, edc, ep;
  } vec_t;
  vec_t tbl[10];

  // ---------------- randomized traffic with reference model ----------------
  typedef struct {
    int            side;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  op_t           pend[$];
  op_t           done[$];
  int            gaps[$];
  logic [DW-1:0] memarr [logic [AW-1:0]];
  logic          act[2];
  logic          jdone[2];
  op_t           cur[2];
  int            owner_m;
  logic          last_d_m;
  logic          busy, mwr, spur, gap_armed;
  int            mcnt, lat_fix, prob, gap_cnt;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwd;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (memarr.exists(a)) return memarr[a];
    return {4{{4'h0, a}}};
  endfunction

  task automatic push_op(input int side, input logic wr, input logic [AW-1:0] a);
    op_t o;
    o.side = side; o.wr = wr; o.addr = a; o.data = rnd128();
    pend.push_back(o);
  endtask

  task automatic record(input int s, input logic [DW-1:0] rd);
    op_t o;
    o = cur[s];
    if (!o.wr) begin
      chk("rnd.read_data", rd, mem_val(o.addr));
      o.data = rd;
    end
    done.push_back(o);
    jdone[s] = 1'b1;
    gap_armed = 1'b1;
    gap_cnt = 0;
  endtask

  task automatic step();
    int   idx;
    logic icq, dcq;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      if (jdone[s]) begin
        act[s] = 1'b0; jdone[s] = 1'b0;
      end else if (!act[s]) begin
        idx = -1;
        for (int i = 0; i < pend.size(); i++) if (idx < 0 && pend[i].side == s) idx = i;
        if (idx < 0 && prob > 0 && int'($urandom_range(99)) < prob) begin
          push_op(s, 1'($urandom_range(1)), AW'($urandom_range(7) * 16));
          idx = pend.size() - 1;
        end
        if (idx >= 0) begin
          cur[s] = pend[idx]; pend.delete(idx); act[s] = 1'b1;
        end
      end
    end
    ic_mem_read  = act[0] && !cur[0].wr;
    ic_mem_write = act[0] && cur[0].wr;
    ic_mem_addr  = act[0] ? cur[0].addr : AW'($urandom);
    ic_mem_wdata = act[0] ? cur[0].data : rnd128();
    dc_mem_read  = act[1] && !cur[1].wr;
    dc_mem_write = act[1] && cur[1].wr;
    dc_mem_addr  = act[1] ? cur[1].addr : AW'($urandom);
    dc_mem_wdata = act[1] ? cur[1].data : rnd128();
    mem_rdata = rnd128();
    if (busy && mcnt == 0) begin
      mem_ready = 1'b1;
      if (!mwr) mem_rdata = mem_val(maddr);
    end else if (!busy && spur && owner_m == 0 && $urandom_range(7) == 0) begin
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'b0;
    end
    #1;
    check_cycle("rnd", owner_m, (owner_m == 1) && mem_ready, (owner_m == 2) && mem_ready, 1'b0);
    if (gap_armed) begin
      if (mem_read || mem_write) begin
        gaps.push_back(gap_cnt); gap_armed = 1'b0;
      end else begin
        gap_cnt++;
      end
    end
    if (ic_mem_ready && act[0]) record(0, ic_mem_rdata);
    if (dc_mem_ready && act[1]) record(1, dc_mem_rdata);
    // memory side bookkeeping
    if (mem_ready && busy) begin
      if (mwr) memarr[maddr] = mwd;
      busy = 1'b0;
    end else if (!busy && !mem_ready && (mem_read || mem_write)) begin
      busy = 1'b1; mwr = mem_write; maddr = mem_addr; mwd = mem_wdata;
      mcnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(3));
    end else if (busy && mcnt > 0) begin
      mcnt--;
    end
    // reference arbitration: idle picks the only requester, or the one not served last
    icq = ic_mem_read | ic_mem_write;
    dcq = dc_mem_read | dc_mem_write;
    if (owner_m == 0) begin
      if (icq && dcq)  owner_m = last_d_m ? 1 : 2;
      else if (icq)    owner_m = 1;
      else if (dcq)    owner_m = 2;
      if (owner_m != 0) last_d_m = (owner_m == 2);
    end else if (mem_ready || !((owner_m == 1) ? icq : dcq)) begin
      owner_m = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ic_mem_read = 1'b0; ic_mem_write = 1'b0; dc_mem_read = 1'b0;
    dc_mem_write = 1'b0; mem_ready = 1'b0; ic_mem_addr = '0; dc_mem_addr = '0;
    ic_mem_wdata = '0; dc_mem_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    owner_m = 0; last_d_m = 1'b0; busy = 1'b0; mcnt = 0; gap_armed = 1'b0; gap_cnt = 0;
    act[0] = 1'b0; act[1] = 1'b0; jdone[0] = 1'b0; jdone[1] = 1'b0;
    pend.delete(); done.delete(); gaps.delete();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (done.size() < n && c < budget) begin
      step();
      c++;
    end
    chk({tag, ".completions"}, DW'(done.size()), DW'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_side[6];
    int g;
    rst_n = 1'b0; ic_mem_read = 1'b0; ic_mem_write = 1'b0; dc_mem_read = 1'b0;
    dc_mem_write = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    ic_mem_addr = 28'h0000123; dc_mem_addr = 28'h00000A0;
    ic_mem_wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    dc_mem_wdata = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    repeat (2) @(negedge clk);

    // r, icr, icw, dcr, dcw, mrdy, owner, ic_rdy, dc_rdy, perr
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].r, tbl[i].icr, tbl[i].icw, tbl[i].dcr, tbl[i].dcw,
          tbl[i].mr, tbl[i].owner, tbl[i].eic, tbl[i].edc, tbl[i].ep);
    end

    // ICACHE alone reads 0x123
    do_reset();
    prob = 0; spur = 1'b0; lat_fix = 4;
    memarr[28'h0000123] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    push_op(0, 1'b0, 28'h0000123);
    run_until("ic_only", 1, 40);
    if (done.size() > 0) begin
      chk("ic_only.side", DW'(done[0].side), DW'(0));
      chk("ic_only.rdata", done[0].data, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    end
    repeat (2) step();

    // continuous contention: D,I,D,I,D,I with one idle cycle between grants
    do_reset();
    prob = 100; lat_fix = -1;
    run_until("contend", 6, 200);
    exp_side = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      g = (i < done.size()) ? done[i].side : -1;
      chk($sformatf("contend.order%0d", i), DW'(g), DW'(exp_side[i]));
    end
    for (int i = 0; i < 5; i++) begin
      g = (i < gaps.size()) ? gaps[i] : -1;
      chk($sformatf("contend.gap%0d", i), DW'(g), DW'(1));
    end

    // DCACHE write-back then refill while ICACHE waits
    do_reset();
    prob = 0;
    push_op(1, 1'b1, 28'h00000A0);
    push_op(1, 1'b0, 28'h00000B0);
    push_op(0, 1'b0, 28'h0000123);
    run_until("wb", 3, 100);
    if (done.size() == 3) begin
      chk("wb.first_side",  DW'(done[0].side), DW'(1));
      chk("wb.first_wr",    DW'(done[0].wr),   DW'(1));
      chk("wb.first_addr",  DW'(done[0].addr), DW'(28'h00000A0));
      chk("wb.second_side", DW'(done[1].side), DW'(0));
      chk("wb.third_side",  DW'(done[2].side), DW'(1));
      chk("wb.third_addr",  DW'(done[2].addr), DW'(28'h00000B0));
    end

    // randomized traffic with spurious idle-time ready pulses
    do_reset();
    prob = 35; spur = 1'b1; lat_fix = -1;
    repeat (3000) step();

    // timeout: grant held, error raised after TO waiting cycles, flow still completes
    do_reset();
    ic_mem_addr = 28'h0000123; dc_mem_addr = 28'h00000A0;
    ic_mem_wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    dc_mem_wdata = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    cyc("to_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= TO + 2; k++) begin
      cyc($sformatf("to_wait%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0,
          (k > TO) ? 1'b1 : 1'b0);
    end
    cyc("to_done",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1);
    cyc("to_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // reset in the middle of an ICACHE grant, then a stray mem_ready in IDLE
    cyc("rm_idle",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc("rm_grant", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    cyc("rm_rst",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    cyc("rm_rst2",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc("rm_rdy",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc("rm_post",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // owner drives read and write together
    cyc("bs_idle",  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc("bs_grant", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    cyc("bs_rdy",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b1);
    cyc("bs_end",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the ICACHE and DCACHE miss/write-back engines.
- Sits between both caches and the memory model. Each cache drives its request exactly as it would drive a private memory port.
- Uses a registered grant FSM with round-robin fairness, owner-only routing of ready/rdata, and a watchdog that flags protocol violations.

Parameters:
- ADDR_W, 28, memory block address width.
- DATA_W, 128, memory block data width.
- TIMEOUT, 1023, maximum cycles a grant may wait for mem_ready before the error flag is raised. The timeout counter width is ceil(log2(TIMEOUT+1)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- ic_mem_read  input  1  ICACHE block read request; held until ic_mem_ready.
- ic_mem_write  input  1  ICACHE write request; held until ic_mem_ready.
- ic_mem_addr  input  ADDR_W  ICACHE block address.
- ic_mem_wdata  input  DATA_W  ICACHE write data.
- ic_mem_rdata  output  DATA_W  read data returned to ICACHE.
- ic_mem_ready  output  1  one-cycle completion pulse to ICACHE.
- dc_mem_read  input  1  DCACHE block read request; held until dc_mem_ready.
- dc_mem_write  input  1  DCACHE write request; held until dc_mem_ready.
- dc_mem_addr  input  ADDR_W  DCACHE block address.
- dc_mem_wdata  input  DATA_W  DCACHE write data.
- dc_mem_rdata  output  DATA_W  read data returned to DCACHE.
- dc_mem_ready  output  1  one-cycle completion pulse to DCACHE.
- mem_read  output  1  shared port read strobe.
- mem_write  output  1  shared port write strobe.
- mem_addr  output  ADDR_W  shared port address.
- mem_wdata  output  DATA_W  shared port write data.
- mem_rdata  input  DATA_W  shared port read data.
- mem_ready  input  1  shared port completion pulse.
- proto_err  output  1  sticky; set on timeout or on owner dropping its request mid-grant.

Behaviour:
- States:
  - IDLE: no owner; all mem_* strobes 0.
  - GRANT_I: ICACHE owns the port.
  - GRANT_D: DCACHE owns the port.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; last_grant becomes I, so DCACHE wins the first tie.
  - Timeout counter is cleared and proto_err is cleared.
  - All outputs read 0 from that edge on: mem_read, mem_write, mem_addr, mem_wdata, both ready, both rdata.
  - Reset mid-grant abandons the transaction; the memory is reset by the same rst_n.
- Arbitration in IDLE (registered, 1-cycle grant latency):
  - A request is (x_mem_read | x_mem_write).
  - Only I requesting -> GRANT_I. Only D requesting -> GRANT_D.
  - Both requesting -> grant the one that is not last_grant.
  - No request -> stay in IDLE.
  - last_grant updates on grant.
- In GRANT_x:
  - mem_read, mem_write, mem_addr and mem_wdata are combinationally the owner's inputs. The other requester's inputs are ignored.
  - x_mem_ready = mem_ready and x_mem_rdata = mem_rdata, both in the same cycle.
  - The non-owner's ready is always 0. The non-owner's rdata is held at 0 throughout.
  - When mem_ready=1, the next state is IDLE. This gives at least one bubble cycle between grants; back-to-back transactions from the same requester (write-back then refill) therefore take ≥1 idle cycle between them.
- Requester rule: the requester deasserts its read/write in the cycle after its ready. In that IDLE cycle the arbiter sees the current request levels.
- Fairness:
  - Under continuous contention, grants alternate D, I, D, I…
  - A waiting requester is served within one foreign transaction.
- Timeout counter:
  - Clears on entering a grant and increments each grant cycle without mem_ready.
  - Reaching TIMEOUT sets proto_err. The grant is held; there is no forced release.
- Owner read and write both 0 in GRANT_x without mem_ready:
  - Sets proto_err and returns to IDLE next cycle. mem strobes follow the owner, so they are 0 that cycle.
- Owner read and write both 1: proto_err is set; both strobes are passed through.
- mem_ready arriving in IDLE: ignored; no ready pulse to either requester.
- proto_err clears only by reset.

Test Plan:
- Reset with both requests held high -> all outputs 0. First edge after release: GRANT_D, mem_read=dc_mem_read, mem_addr=dc_mem_addr.
- ICACHE alone reads addr 0x0000123, memory ready after 5 cycles with rdata 0xDEADBEEF… -> ic_mem_ready is a 1-cycle pulse with that data. dc_mem_ready stays 0. FSM returns to IDLE the next cycle.
- Both request continuously for 6 transactions -> grant order D,I,D,I,D,I, with exactly one IDLE cycle between grants.
- DCACHE write-back of addr 0x00000A0 followed by refill of 0x00000B0 while ICACHE waits -> order is D-write, I-read, D-read.
- mem_ready withheld for TIMEOUT cycles -> proto_err=1 at cycle TIMEOUT and stays 1. After a later mem_ready the flow completes normally with proto_err still 1.
- Reset asserted mid-GRANT_I, then mem_ready pulsed in IDLE -> no ready to either requester, mem_read=0, proto_err=0.
